// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch slice: instruction word, fetch entry and fetch FSM states.
package instr_fetch_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned PHY_ADDR_SIZE = 32;
  localparam int unsigned ILEN          = 32;

  typedef logic [ILEN-1:0] instruction_t;

  typedef struct packed {
    instruction_t    instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    FAULT_WAIT = 2'd2
  } fetch_state_e;

  // Clear the byte-offset bits of a PC.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO of fetch entries with single-cycle flush; DEPTH must be a power of 2.
module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   cnt_q;

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Storage array, not reset: entries are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  // Upstream credit accounting must make overflow and underflow impossible.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && full));
      assert (!(pop && empty));
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// In-order instruction fetch: issues word reads to imem, buffers responses and hands them to decode.
// Optional build macro INSTR_FETCH_PERF_EN adds perf_fetched_o / perf_stall_o counters.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid_o,
  input  logic                     imem_req_ready_i,
  output logic [PHY_ADDR_SIZE-1:0] imem_req_addr_o,
  input  logic                     imem_rsp_valid_i,
  input  logic [31:0]              imem_rsp_data_i,
  input  logic                     imem_rsp_err_i,
  input  logic                     redirect_valid_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [31:0]              instr_o,
  output logic [XLEN-1:0]          instr_pc_o,
  output logic                     instr_fault_o
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched_o,
  output logic [31:0]              perf_stall_o
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   outst_q;
  logic [CW-1:0]   drop_q;

  fetch_entry_t    fifo_head;
  fetch_entry_t    push_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  logic            req_fire;
  logic            pop;
  logic            rsp_live;
  logic [CW:0]     inflight;
  logic [XLEN-1:0] rsp_pc;

  assign req_fire = imem_req_valid_o && imem_req_ready_i;
  assign pop      = instr_valid_o && instr_ready_i && !redirect_valid_i;
  assign rsp_live = imem_rsp_valid_i && (drop_q == '0) && !redirect_valid_i;
  // Entry about to leave this cycle frees its credit immediately, sustaining 1 instr/cycle.
  assign inflight = (CW+1)'(outst_q) + (CW+1)'(fifo_count) - (CW+1)'(pop);
  // Oldest live request address: pc has advanced once per outstanding request.
  assign rsp_pc   = pc_q - (XLEN'(outst_q) << 2);

  assign push_data = '{instr: imem_rsp_err_i ? '0 : imem_rsp_data_i,
                       pc:    rsp_pc,
                       fault: imem_rsp_err_i};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state; redirect overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = FETCH;
      FETCH:      if (rsp_live && imem_rsp_err_i) state_d = FAULT_WAIT;
      FAULT_WAIT: state_d = FAULT_WAIT;
      default:    state_d = IDLE;
    endcase
    if (redirect_valid_i) state_d = FETCH;
  end

  // FSM outputs: request only while fetching, not redirecting, and with a free credit.
  always_comb begin
    imem_req_valid_o = 1'b0;
    if (state_q == FETCH && !redirect_valid_i && inflight < (CW+1)'(FIFO_DEPTH))
      imem_req_valid_o = 1'b1;
  end

  // Fetch PC, outstanding-request count and count of responses still to discard.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else if (redirect_valid_i) begin
      pc_q    <= word_align(redirect_pc_i);
      outst_q <= outst_q - CW'(imem_rsp_valid_i);
      drop_q  <= outst_q - CW'(imem_rsp_valid_i);
    end else begin
      if (req_fire) pc_q <= pc_q + XLEN'(4);
      outst_q <= outst_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
      if (imem_rsp_valid_i && drop_q != '0) drop_q <= drop_q - CW'(1);
    end
  end

  instr_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_live),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid_i),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign imem_req_addr_o = PHY_ADDR_SIZE'(pc_q);
  assign instr_valid_o   = !fifo_empty;
  assign instr_o         = fifo_empty ? '0 : fifo_head.instr;
  assign instr_pc_o      = fifo_empty ? '0 : fifo_head.pc;
  assign instr_fault_o   = fifo_empty ? 1'b0 : fifo_head.fault;

`ifdef INSTR_FETCH_PERF_EN
  // Delivered-instruction and fetch-starvation counters; free-running, wrap on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (pop) perf_fetched_o <= perf_fetched_o + 32'd1;
      if (state_q == FETCH && !instr_valid_o) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule
